// File: rtl/buck_phase_sequencer.sv
// ----------------------------------------------------------------------------
// buck_phase_sequencer
//
// Clocked gate sequencer for a synchronous buck power stage. One switching
// cycle is: PMOS on (charge) -> dead time -> NMOS on (freewheel) -> dead time.
// Break-before-make, dead time, minimum on-time and ack timeouts are enforced
// here. The uv/oc/zc comparator flags and the driver acks are asynchronous
// and pass through 2-flop synchronizers, so every decision sees them two
// cycles late.
//
// Gate handshake: a gate request (gp/gn) is a level held by this block. A
// request rises only when the other gate's synchronized ack is 0. It is held
// until its own ack is seen high, and after it falls the block waits for the
// ack to return low before moving on. An ack edge that does not arrive within
// ACK_TO_CYC cycles sends the FSM to the sticky FAULT state.
//
// Optional feature (compile-time macro BUCK_SEQ_MAXON_EN):
//   defined   : the PMOS phase is also ended after MAX_ON_CYC held cycles
//               when oc never arrives (no fault is raised).
//   undefined : the PMOS phase ends only on oc or en=0; MAX_ON_CYC unused.
//
// Ports:
//   clk        in   system clock
//   nrst       in   asynchronous active-low reset (released synchronously)
//   en         in   converter enable (synchronous to clk)
//   uv         in   output undervoltage flag, 1 = charge requested
//   oc         in   inductor peak-current flag, ends the PMOS phase
//   zc         in   inductor zero-crossing flag, ends the NMOS phase
//   gp_ack     in   PMOS driver acknowledge, follows gp
//   gn_ack     in   NMOS driver acknowledge, follows gn
//   gp         out  PMOS gate request (1 = on), registered
//   gn         out  NMOS gate request (1 = on), registered
//   busy       out  1 in any state except IDLE/FAULT, registered
//   fault      out  sticky ack-timeout fault, registered
//   phase      out  0 idle, 1 PMOS, 2 NMOS, 3 dead/fault, registered
//   state_dbg  out  current FSM state encoding, for debug/checkers
// ----------------------------------------------------------------------------
module buck_phase_sequencer #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DEAD_CYC   = 4,
    parameter int unsigned MIN_ON_CYC = 8,
    parameter int unsigned ACK_TO_CYC = 16,
    parameter int unsigned MAX_ON_CYC = 200
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       uv,
    input  logic       oc,
    input  logic       zc,
    input  logic       gp_ack,
    input  logic       gn_ack,
    output logic       gp,
    output logic       gn,
    output logic       busy,
    output logic       fault,
    output logic [1:0] phase,
    output logic [3:0] state_dbg
);

    // Every cycle count must be reachable by the saturating counter.
    generate
        if (CNT_W < 1 || CNT_W > 16 ||
            DEAD_CYC < 1 || MIN_ON_CYC < 1 || ACK_TO_CYC < 1 || MAX_ON_CYC < 1 ||
            DEAD_CYC > (32'd1 << CNT_W) || MIN_ON_CYC > (32'd1 << CNT_W) ||
            ACK_TO_CYC > (32'd1 << CNT_W) || MAX_ON_CYC > (32'd1 << CNT_W)) begin : g_bad_params
            $error("buck_phase_sequencer: cycle parameters do not fit CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_ON_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TO_CYC - 1);
`ifdef BUCK_SEQ_MAXON_EN
    localparam logic [CNT_W-1:0] MAXON_LAST = CNT_W'(MAX_ON_CYC - 1);
`endif
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_P_REQ  = 4'd1,
        S_P_HOLD = 4'd2,
        S_P_REL  = 4'd3,
        S_DEAD1  = 4'd4,
        S_N_REQ  = 4'd5,
        S_N_HOLD = 4'd6,
        S_N_REL  = 4'd7,
        S_DEAD2  = 4'd8,
        S_FAULT  = 4'd9
    } state_t;

    // ------------------------------------------------------------------
    // Reset synchronizer: assertion is immediate, release takes two edges.
    // ------------------------------------------------------------------
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Input synchronizers, bit order {uv, oc, zc, gp_ack, gn_ack}.
    // ------------------------------------------------------------------
    logic [4:0] sync1_q;
    logic [4:0] sync2_q;

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {uv, oc, zc, gp_ack, gn_ack};
            sync2_q <= sync1_q;
        end
    end

    logic uv_s, oc_s, zc_s, gp_ack_s, gn_ack_s;
    assign {uv_s, oc_s, zc_s, gp_ack_s, gn_ack_s} = sync2_q;

    // ------------------------------------------------------------------
    // FSM next state and counter
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             gp_q, gp_d;
    logic             gn_q, gn_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic [1:0]       phase_q, phase_d;

    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en && uv_s && !gn_ack_s) state_d = S_P_REQ;
            end
            S_P_REQ: begin
                if (!en) begin
                    state_d = S_P_REL;
                    cnt_d   = '0;
                end else if (gp_ack_s) begin
                    state_d = S_P_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end
            end
            S_P_HOLD: begin
                // oc before the minimum on-time is ignored; shutdown is not.
                if (!en || (oc_s && cnt_q >= MIN_LAST)) begin
                    state_d = S_P_REL;
                    cnt_d   = '0;
                end
`ifdef BUCK_SEQ_MAXON_EN
                else if (cnt_q == MAXON_LAST) begin
                    state_d = S_P_REL;
                    cnt_d   = '0;
                end
`endif
            end
            S_P_REL: begin
                if (!gp_ack_s) begin
                    state_d = S_DEAD1;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end
            end
            S_DEAD1: begin
                // When disabled, the dead time still completes, but no NMOS
                // pulse is started: both gates and acks are already low.
                if (cnt_q >= DEAD_LAST) begin
                    if (!en) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (!gp_ack_s) begin
                        state_d = S_N_REQ;
                        cnt_d   = '0;
                    end
                end
            end
            S_N_REQ: begin
                if (!en) begin
                    state_d = S_N_REL;
                    cnt_d   = '0;
                end else if (gn_ack_s) begin
                    state_d = S_N_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end
            end
            S_N_HOLD: begin
                if (!en || (zc_s && cnt_q >= MIN_LAST)) begin
                    state_d = S_N_REL;
                    cnt_d   = '0;
                end
            end
            S_N_REL: begin
                if (!gn_ack_s) begin
                    state_d = S_DEAD2;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end
            end
            S_DEAD2: begin
                if (cnt_q >= DEAD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_FAULT: begin
                cnt_d = '0;
                if (!en) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the current state and are then registered, so they
    // follow a state change by one cycle.
    always_comb begin
        gp_d    = (state_q == S_P_REQ) || (state_q == S_P_HOLD);
        gn_d    = (state_q == S_N_REQ) || (state_q == S_N_HOLD);
        busy_d  = (state_q != S_IDLE) && (state_q != S_FAULT);
        fault_d = (state_q == S_FAULT);
        unique case (state_q)
            S_IDLE:                     phase_d = 2'd0;
            S_P_REQ, S_P_HOLD, S_P_REL: phase_d = 2'd1;
            S_N_REQ, S_N_HOLD, S_N_REL: phase_d = 2'd2;
            default:                    phase_d = 2'd3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gp_q    <= 1'b0;
            gn_q    <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gp_q    <= gp_d;
            gn_q    <= gn_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            phase_q <= phase_d;
        end
    end

    assign gp        = gp_q;
    assign gn        = gn_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign phase     = phase_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_buck_phase_sequencer.sv
// ----------------------------------------------------------------------------
// tb_buck_phase_sequencer
//
// Directed bench. A small power-stage model answers the gates: each ack
// follows its gate two cycles late, oc rises once gp has been on for oc_dly
// cycles and zc once gn has been on for zc_dly cycles. Each stimulus pushes
// the hand-derived output changes it causes, tagged with the absolute cycle
// at which they must appear, onto exp_q. The monitor samples outputs on the
// falling edge and pops one entry for every change it sees.
// ----------------------------------------------------------------------------
module tb_buck_phase_sequencer;

    localparam int W = 38;  // {cycle[31:0], phase[1:0], gp, gn, busy, fault}

    logic       clk  = 1'b0;
    logic       nrst = 1'b1;
    logic       en   = 1'b0;
    logic       uv   = 1'b0;
    logic       oc, zc, gp_ack, gn_ack;
    logic       gp, gn, busy, fault;
    logic [1:0] phase;
    logic [3:0] state_dbg;

    int         cyc = 0;
    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic [5:0] prev_obs = '0;

    // Power-stage model
    int   oc_dly = 100000;
    int   zc_dly = 100000;
    int   oc_cnt = 0;
    int   zc_cnt = 0;
    logic gp_stuck = 1'b0;
    logic gp_d1 = 1'b0, gp_d2 = 1'b0, gn_d1 = 1'b0, gn_d2 = 1'b0;

    // ---------------- clock / reset-independent housekeeping ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- environment model ----------------
    always @(posedge clk) begin
        gp_d1  <= gp;
        gp_d2  <= gp_d1;
        gn_d1  <= gn;
        gn_d2  <= gn_d1;
        oc_cnt <= gp ? oc_cnt + 1 : 0;
        zc_cnt <= gn ? zc_cnt + 1 : 0;
    end
    assign gp_ack = gp_d2 & ~gp_stuck;
    assign gn_ack = gn_d2;
    assign oc     = (oc_cnt >= oc_dly);
    assign zc     = (zc_cnt >= zc_dly);

    buck_phase_sequencer dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .uv        (uv),
        .oc        (oc),
        .zc        (zc),
        .gp_ack    (gp_ack),
        .gn_ack    (gn_ack),
        .gp        (gp),
        .gn        (gn),
        .busy      (busy),
        .fault     (fault),
        .phase     (phase),
        .state_dbg (state_dbg)
    );

    function automatic logic [5:0] outs();
        return {phase, gp, gn, busy, fault};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [5:0]   obs;
        logic [W-1:0] e;
        if (mon_en) begin
            obs = outs();
            vec_cnt++;
            if ((gp && gn) || (gp && gn_ack) || (gn && gp_ack)) begin
                err_cnt++;
                $display("FAIL gate_overlap: cyc=%0d gp=%b gn=%b gp_ack=%b gn_ack=%b, required no overlap",
                         cyc, gp, gn, gp_ack, gn_ack);
            end
            if (obs !== prev_obs) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL unexpected_event: cyc=%0d out=%b (was %b), none expected",
                             cyc, obs, prev_obs);
                end else begin
                    e = exp_q.pop_front();
                    if (e !== {32'(cyc), obs}) begin
                        err_cnt++;
                        $display("FAIL event: got cyc=%0d out=%b, required cyc=%0d out=%b",
                                 cyc, obs, e[37:6], e[5:0]);
                    end
                end
            end
            prev_obs = obs;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic exp_ev(input int c, input logic [1:0] ph,
                          input logic p, input logic n, input logic b, input logic f);
        exp_q.push_back({32'(c), ph, p, n, b, f});
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_cycle(output int k);
        @(posedge clk);
        #1;
        en = 1'b1;
        uv = 1'b1;
        k  = cyc;
    endtask

    task automatic check_out(input string name, input logic [5:0] want);
        vec_cnt++;
        if (outs() !== want) begin
            err_cnt++;
            $display("FAIL %s: got out=%b, required %b", name, outs(), want);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;

        // T1: reset state, release with en=0 stays idle
        #2 nrst = 1'b0;
        #1 check_out("reset_outputs", 6'b00_0000);
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        wait_to(cyc + 12);
        check_out("idle_after_release", 6'b00_0000);

        // T2: full cycle, oc after 20 gp-on cycles, zc after 30 gn-on cycles
        oc_dly = 20;
        zc_dly = 30;
        start_cycle(k);
        exp_ev(k + 4,  2'd1, 1, 0, 1, 0);
        exp_ev(k + 28, 2'd1, 0, 0, 1, 0);
        exp_ev(k + 34, 2'd3, 0, 0, 1, 0);
        exp_ev(k + 38, 2'd2, 0, 1, 1, 0);
        exp_ev(k + 72, 2'd2, 0, 0, 1, 0);
        exp_ev(k + 78, 2'd3, 0, 0, 1, 0);
        exp_ev(k + 82, 2'd0, 0, 0, 0, 0);
        wait_to(k + 10);
        uv = 1'b0;
        wait_to(k + 20);
        check_out("t2_pmos_hold", 6'b01_1010);
        wait_to(k + 95);

        // T3: oc and zc already high -> each gate held exactly min-on
        oc_dly = 0;
        zc_dly = 0;
        start_cycle(k);
        exp_ev(k + 4,  2'd1, 1, 0, 1, 0);
        exp_ev(k + 18, 2'd1, 0, 0, 1, 0);
        exp_ev(k + 24, 2'd3, 0, 0, 1, 0);
        exp_ev(k + 28, 2'd2, 0, 1, 1, 0);
        exp_ev(k + 42, 2'd2, 0, 0, 1, 0);
        exp_ev(k + 48, 2'd3, 0, 0, 1, 0);
        exp_ev(k + 52, 2'd0, 0, 0, 0, 0);
        wait_to(k + 10);
        uv = 1'b0;
        wait_to(k + 65);

        // T5: en=0 during N_HOLD; uv stays 1 but no new PMOS pulse
        oc_dly = 20;
        zc_dly = 100000;
        start_cycle(k);
        exp_ev(k + 4,  2'd1, 1, 0, 1, 0);
        exp_ev(k + 28, 2'd1, 0, 0, 1, 0);
        exp_ev(k + 34, 2'd3, 0, 0, 1, 0);
        exp_ev(k + 38, 2'd2, 0, 1, 1, 0);
        wait_to(k + 50);
        en = 1'b0;
        exp_ev(k + 52, 2'd2, 0, 0, 1, 0);
        exp_ev(k + 58, 2'd3, 0, 0, 1, 0);
        exp_ev(k + 62, 2'd0, 0, 0, 0, 0);
        wait_to(k + 100);
        check_out("t5_idle_after_shutdown", 6'b00_0000);
        uv = 1'b0;
        wait_to(k + 106);

        // T6: oc never arrives
        oc_dly = 100000;
        zc_dly = 0;
        start_cycle(k);
        exp_ev(k + 4, 2'd1, 1, 0, 1, 0);
        wait_to(k + 10);
        uv = 1'b0;
`ifdef BUCK_SEQ_MAXON_EN
        exp_ev(k + 210, 2'd1, 0, 0, 1, 0);
        exp_ev(k + 216, 2'd3, 0, 0, 1, 0);
        exp_ev(k + 220, 2'd2, 0, 1, 1, 0);
        exp_ev(k + 234, 2'd2, 0, 0, 1, 0);
        exp_ev(k + 240, 2'd3, 0, 0, 1, 0);
        exp_ev(k + 244, 2'd0, 0, 0, 0, 0);
        wait_to(k + 260);
        en = 1'b0;
        wait_to(k + 270);
`else
        wait_to(k + 250);
        check_out("t6_gp_still_on", 6'b01_1010);
        en = 1'b0;
        exp_ev(k + 252, 2'd1, 0, 0, 1, 0);
        exp_ev(k + 258, 2'd3, 0, 0, 1, 0);
        exp_ev(k + 262, 2'd0, 0, 0, 0, 0);
        wait_to(k + 275);
`endif

        // T4: gp_ack stuck low -> fault after 16 cycles in P_REQ, cleared by en=0
        gp_stuck = 1'b1;
        start_cycle(k);
        exp_ev(k + 4,  2'd1, 1, 0, 1, 0);
        exp_ev(k + 20, 2'd3, 0, 0, 0, 1);
        wait_to(k + 35);
        check_out("t4_fault_sticky", 6'b11_0001);
        wait_to(k + 40);
        en = 1'b0;
        uv = 1'b0;
        exp_ev(k + 42, 2'd0, 0, 0, 0, 0);
        wait_to(k + 50);
        gp_stuck = 1'b0;
        wait_to(k + 56);

        // T7: nrst asserted mid-phase drops the gate without waiting for clk
        oc_dly = 100000;
        start_cycle(k);
        exp_ev(k + 4, 2'd1, 1, 0, 1, 0);
        wait_to(k + 20);
        #2;
        exp_ev(k + 20, 2'd0, 0, 0, 0, 0);
        nrst = 1'b0;
        #1 check_out("async_reset_drop", 6'b00_0000);
        en = 1'b0;
        uv = 1'b0;
        repeat (4) @(posedge clk);
        #1 nrst = 1'b1;
        wait_to(cyc + 15);
        check_out("idle_after_mid_reset", 6'b00_0000);

        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL exp_queue_drain: %0d events never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
